bitgen_obstacle_sprites: RTL and testbench

Parametrised scrolling-obstacle sprite generator for the VGA path. It tracks NUM_OBS obstacle positions that move left once per frame at a programmable speed and respawn at the right edge. It fetches 16-bit RGB565 pixels from the shared synchronous sprite ROM and produces registered 8-bit RGB plus an opacity flag for the downstream compositor. It replaces the fixed-position single-cactus generator and sits between the VGA timing counters and the layer mixer.

---
 rtl/bitgen_obstacle_sprites.sv | 108 ++++++++++
 tb/tb_bitgen_obstacle_sprites.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/bitgen_obstacle_sprites.sv
// bitgen_obstacle_sprites: scrolling obstacle sprites, 3-stage ROM-fetch pipeline to registered RGB888 + opacity.
module bitgen_obstacle_sprites #(
  parameter int             NUM_OBS           = 2,
  parameter int             SPRITE_WIDTH      = 32,
  parameter int             SPRITE_HEIGHT     = 32,
  parameter int             SCALE             = 3,
  parameter logic [12:0]    BASE_ADDR         = 13'd4096,
  parameter int             OBS_Y             = 192,
  parameter int             SPACING           = 320,
  parameter int             SCREEN_WIDTH      = 640,
  parameter int             SCREEN_HEIGHT     = 480,
  parameter logic [15:0]    TRANSPARENT_COLOR = 16'hF81F,
  parameter logic [7:0]     BG_R              = 8'h88,
  parameter logic [7:0]     BG_G              = 8'hCC,
  parameter logic [7:0]     BG_B              = 8'h88
) (
  input  logic                   pix_clk,
  input  logic                   rst_n,
  input  logic                   bright,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   run,
  input  logic [3:0]             speed,
  input  logic                   restart,
  input  logic [15:0]            sprite_data,
  output logic [12:0]            sprite_addr,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b,
  output logic                   pixel_opaque,
  output logic [11*NUM_OBS-1:0]  obs_x
);
  localparam int SW = SPRITE_WIDTH * SCALE;
  localparam int SH = SPRITE_HEIGHT * SCALE;
  localparam logic [10:0] RESPAWN = 11'(SCREEN_WIDTH + SW);
  logic [10:0] x_q [NUM_OBS];
  logic [10:0] x_d [NUM_OBS];
  logic [NUM_OBS-1:0] hit;
  logic [10:0] sel_x;
  logic        hit_any;
  logic        frame_tick;
  logic        in_rows;
  logic [11:0] hx;
  logic [11:0] sx;
  logic [9:0]  sy;
  logic [12:0] offset;
  logic [12:0] addr_d;
  logic        hit_d1_q, bright_d1_q, hit_d2_q, bright_d2_q;
  logic        opaque_d;
  logic [7:0]  r_d, g_d, b_d;
  assign frame_tick = (vcount == 10'(SCREEN_HEIGHT)) && (hcount == 10'd0);
  // Box tests run in biased space (hcount+SW) so off-screen-left positions stay unsigned.
  assign hx      = {2'b0, hcount} + 12'(SW);
  assign in_rows = (vcount >= 10'(OBS_Y)) && (vcount < 10'(OBS_Y + SH));
  always_comb begin
    for (int i = 0; i < NUM_OBS; i++) begin
      x_d[i] = restart ? 11'(SCREEN_WIDTH + SW + i * SPACING)
             : (frame_tick && run) ? ((x_q[i] > 11'(speed)) ? x_q[i] - 11'(speed) : RESPAWN)
             : x_q[i];
      hit[i] = bright && in_rows && (hx >= {1'b0, x_q[i]}) && (hx < {1'b0, x_q[i]} + 12'(SW));
    end
  end
  // Walk downwards so the lowest-index hit is the one left in sel_x.
  always_comb begin
    sel_x   = x_q[0];
    hit_any = 1'b0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      sel_x   = hit[i] ? x_q[i] : sel_x;
      hit_any = hit_any | hit[i];
    end
  end
  assign sx     = hx - {1'b0, sel_x};
  assign sy     = vcount - 10'(OBS_Y);
  assign offset = 13'(32'(sy) / SCALE * SPRITE_WIDTH + 32'(sx) / SCALE);
  assign addr_d = hit_any ? BASE_ADDR + offset : BASE_ADDR;
  assign opaque_d = bright_d2_q && hit_d2_q && (sprite_data != TRANSPARENT_COLOR);
  assign r_d = !bright_d2_q ? 8'h00 : opaque_d ? {sprite_data[15:11], sprite_data[15:13]} : BG_R;
  assign g_d = !bright_d2_q ? 8'h00 : opaque_d ? {sprite_data[10:5], sprite_data[10:9]} : BG_G;
  assign b_d = !bright_d2_q ? 8'h00 : opaque_d ? {sprite_data[4:0], sprite_data[4:2]} : BG_B;
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBS; i++) x_q[i] <= 11'(SCREEN_WIDTH + SW + i * SPACING);
      sprite_addr  <= BASE_ADDR;
      hit_d1_q     <= 1'b0;
      bright_d1_q  <= 1'b0;
      hit_d2_q     <= 1'b0;
      bright_d2_q  <= 1'b0;
      vga_r        <= 8'h00;
      vga_g        <= 8'h00;
      vga_b        <= 8'h00;
      pixel_opaque <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OBS; i++) x_q[i] <= x_d[i];
      sprite_addr  <= addr_d;
      hit_d1_q     <= hit_any;
      bright_d1_q  <= bright;
      hit_d2_q     <= hit_d1_q;
      bright_d2_q  <= bright_d1_q;
      vga_r        <= r_d;
      vga_g        <= g_d;
      vga_b        <= b_d;
      pixel_opaque <= opaque_d;
    end
  end
  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    assign obs_x[11*g +: 11] = x_q[g];
  end
endmodule

// File: tb/tb_bitgen_obstacle_sprites.sv
// tb_bitgen_obstacle_sprites: directed vectors with hand-computed expectations for the obstacle sprite generator.
module tb_bitgen_obstacle_sprites;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        bright;
  logic [9:0]  hcount, vcount;
  logic        run;
  logic [3:0]  speed;
  logic        restart;
  logic [15:0] rom_val, rom_q;
  logic [12:0] addr, o_addr;
  logic [7:0]  r, g, b, o_r, o_g, o_b;
  logic        opq, o_opq;
  logic [21:0] ox, o_ox;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  always @(posedge clk) rom_q <= rom_val;
  bitgen_obstacle_sprites u_dut (
    .pix_clk(clk), .rst_n(rst_n), .bright(bright), .hcount(hcount), .vcount(vcount),
    .run(run), .speed(speed), .restart(restart), .sprite_data(rom_q),
    .sprite_addr(addr), .vga_r(r), .vga_g(g), .vga_b(b), .pixel_opaque(opq), .obs_x(ox)
  );
  // Tight spacing so obstacles 0 and 1 overlap on screen.
  bitgen_obstacle_sprites #(.SPACING(48)) u_ovl (
    .pix_clk(clk), .rst_n(rst_n), .bright(bright), .hcount(hcount), .vcount(vcount),
    .run(run), .speed(speed), .restart(restart), .sprite_data(rom_q),
    .sprite_addr(o_addr), .vga_r(o_r), .vga_g(o_g), .vga_b(o_b), .pixel_opaque(o_opq), .obs_x(o_ox)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask
  task automatic idle();
    hcount = 10'd0; vcount = 10'd0; bright = 1'b0; restart = 1'b0;
  endtask
  task automatic tick(input logic [3:0] s, input logic rn);
    @(negedge clk);
    vcount = 10'd480; hcount = 10'd0; run = rn; speed = s;
    @(negedge clk);
    idle();
  endtask
  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    idle();
  endtask
  task automatic pix(input int h, input int v, input logic br);
    @(negedge clk);
    hcount = 10'(h); vcount = 10'(v); bright = br;
  endtask
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_rgb(input string tag, input logic [23:0] exp, input logic eo);
    check({tag, "_rgb"}, {8'h0, r, g, b}, {8'h0, exp});
    check({tag, "_opq"}, 32'(opq), 32'(eo));
  endtask
  initial begin
    rst_n = 1'b0; run = 1'b0; speed = 4'd0; rom_val = 16'h0000;
    idle();
    #12;
    check("rst_obs_x", 32'(ox), {10'd0, 11'd1056, 11'd736});
    check("rst_addr", 32'(addr), 32'd4096);
    check_rgb("rst", 24'h000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick(4'd4, 1'b1);
    check("move_x0", 32'(ox[10:0]), 32'd696);
    check("move_x1", 32'(ox[21:11]), 32'd1016);
    repeat (5) tick(4'd0, 1'b1);
    check("speed0_x0", 32'(ox[10:0]), 32'd696);
    repeat (3) tick(4'd4, 1'b0);
    check("run0_x0", 32'(ox[10:0]), 32'd696);
    @(negedge clk);
    restart = 1'b1; vcount = 10'd480; hcount = 10'd0; run = 1'b1; speed = 4'd4;
    @(negedge clk);
    idle();
    check("rst_tick_x0", 32'(ox[10:0]), 32'd736);
    check("rst_tick_x1", 32'(ox[21:11]), 32'd1056);
    repeat (48) tick(4'd15, 1'b1);
    tick(4'd13, 1'b1);
    check("pre_respawn_x0", 32'(ox[10:0]), 32'd3);
    tick(4'd4, 1'b1);
    check("respawn_x0", 32'(ox[10:0]), 32'd736);
    check("respawn_x1", 32'(ox[21:11]), 32'd319);
    do_restart();
    repeat (48) tick(4'd15, 1'b1);
    tick(4'd11, 1'b1);
    check("pre_dec_x0", 32'(ox[10:0]), 32'd5);
    tick(4'd4, 1'b1);
    check("dec_to1_x0", 32'(ox[10:0]), 32'd1);
    do_restart();
    repeat (16) tick(4'd15, 1'b1);
    check("pos_x0", 32'(ox[10:0]), 32'd496);
    check("pos_x1", 32'(ox[21:11]), 32'd816);
    check("ovl_x1", 32'(o_ox[21:11]), 32'd544);
    rom_val = 16'h07E0;
    pix(399, 196, 1'b1);
    edges(3);
    check("left_out_addr", 32'(addr), 32'd4096);
    check_rgb("left_out", 24'h88CC88, 1'b0);
    pix(401, 196, 1'b1);
    edges(1);
    check("hit_addr", 32'(addr), 32'd4128);
    edges(1);
    check_rgb("lat2", 24'h88CC88, 1'b0);
    edges(1);
    check_rgb("lat3", 24'h00FF00, 1'b1);
    rom_val = 16'hF81F;
    edges(3);
    check_rgb("transp", 24'h88CC88, 1'b0);
    rom_val = 16'h07E0;
    pix(495, 287, 1'b1);
    edges(1);
    check("corner_addr", 32'(addr), 32'd5119);
    edges(2);
    check_rgb("corner", 24'h00FF00, 1'b1);
    pix(400, 192, 1'b1);
    edges(3);
    check("origin_addr", 32'(addr), 32'd4096);
    check_rgb("origin", 24'h00FF00, 1'b1);
    pix(496, 287, 1'b1);
    edges(3);
    check("right_out_addr", 32'(addr), 32'd4096);
    check_rgb("right_out", 24'h88CC88, 1'b0);
    pix(401, 288, 1'b1);
    edges(3);
    check_rgb("below", 24'h88CC88, 1'b0);
    pix(401, 196, 1'b0);
    edges(3);
    check("dark_addr", 32'(addr), 32'd4096);
    check_rgb("dark", 24'h000000, 1'b0);
    pix(450, 196, 1'b1);
    edges(1);
    check("overlap_addr", 32'(o_addr), 32'd4144);
    pix(520, 196, 1'b1);
    edges(1);
    check("obs1_addr", 32'(o_addr), 32'd4152);
    pix(401, 196, 1'b1);
    edges(3);
    check_rgb("pre_rst", 24'h00FF00, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_rgb("async_rst", 24'h000000, 1'b0);
    check("async_rst_addr", 32'(addr), 32'd4096);
    check("async_rst_x0", 32'(ox[10:0]), 32'd736);
    @(negedge clk);
    rst_n = 1'b1;
    edges(2);
    check_rgb("post_rst2", 24'h000000, 1'b0);
    edges(1);
    check_rgb("post_rst3", 24'h88CC88, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
